detector_jogada: RTL and testbench

- Input conditioner that sits directly upstream of circuito_exp6 in the Genius game datapath.
- Takes the four raw, asynchronous, bouncing player buttons and synchronises and debounces them.
- Validates that exactly one button is pressed, then emits one registered one-hot play (jogada) with a single-cycle jogada_feita pulse per physical press.
- Replaces the raw botoes-to-edge-detector path feeding the game FSM, so the game never sees bounce, glitches or multi-button presses.

---
 rtl/detector_jogada_pkg.sv | 20 ++
 rtl/sincronizador_2ff.sv | 21 ++
 rtl/detector_jogada.sv | 103 ++++++++++
 tb/tb_detector_jogada.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the player-button conditioner: FSM encoding,
// default debounce length and the one-hot validity check.
package detector_jogada_pkg;

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    ESPERA_PRESSAO = 3'd1,
    FILTRA         = 3'd2,
    PULSO          = 3'd3,
    ESPERA_SOLTAR  = 3'd4,
    FILTRA_SOLTAR  = 3'd5
  } estado_t;

  localparam int DEBOUNCE_PADRAO = 5;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a 4-bit group of asynchronous inputs.
module sincronizador_2ff (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Debounces the four player buttons and emits one registered one-hot play
// with a single-cycle jogada_feita pulse per accepted physical press.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int LARGURA_CONT    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       multipla,
  output logic [2:0] db_estado
);

  localparam logic [LARGURA_CONT-1:0] CNT_FIM = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

  estado_t                 estado, estado_prox;
  logic [LARGURA_CONT-1:0] cnt, cnt_prox;
  logic [3:0]              amostra, amostra_prox;
  logic [3:0]              jogada_prox;
  logic                    multipla_prox;
  logic [3:0]              sinc;

  sincronizador_2ff u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (sinc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= INICIAL;
      cnt      <= '0;
      amostra  <= '0;
      jogada   <= '0;
      multipla <= 1'b0;
    end else begin
      estado   <= estado_prox;
      cnt      <= cnt_prox;
      amostra  <= amostra_prox;
      jogada   <= jogada_prox;
      multipla <= multipla_prox;
    end
  end

  always_comb begin
    estado_prox   = estado;
    cnt_prox      = cnt;
    amostra_prox  = amostra;
    jogada_prox   = jogada;
    multipla_prox = 1'b0;
    case (estado)
      INICIAL: estado_prox = ESPERA_PRESSAO;
      ESPERA_PRESSAO: begin
        if (habilita && sinc != 4'b0000) begin
          amostra_prox = sinc;
          cnt_prox     = '0;
          estado_prox  = FILTRA;
        end
      end
      // Abort beats rejection, which beats the terminal count.
      FILTRA: begin
        if (!habilita) begin
          estado_prox = ESPERA_SOLTAR;
        end else if (sinc != amostra) begin
          estado_prox = ESPERA_PRESSAO;
        end else if (cnt == CNT_FIM) begin
          if (eh_one_hot(amostra)) begin
            jogada_prox = amostra;
            estado_prox = PULSO;
          end else begin
            multipla_prox = 1'b1;
            estado_prox   = ESPERA_SOLTAR;
          end
        end else begin
          cnt_prox = cnt + 1'b1;
        end
      end
      PULSO: estado_prox = ESPERA_SOLTAR;
      ESPERA_SOLTAR: begin
        if (sinc == 4'b0000) begin
          cnt_prox    = '0;
          estado_prox = FILTRA_SOLTAR;
        end
      end
      FILTRA_SOLTAR: begin
        if (sinc != 4'b0000)    estado_prox = ESPERA_SOLTAR;
        else if (cnt == CNT_FIM) estado_prox = ESPERA_PRESSAO;
        else                     cnt_prox    = cnt + 1'b1;
      end
      default: estado_prox = INICIAL;
    endcase
  end

  assign jogada_feita = (estado == PULSO);
  assign db_estado    = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench: each expected play is queued when its press is driven and
// popped by a monitor when jogada_feita pulses.
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       multipla;
  logic [2:0] db_estado;

  int errors = 0;
  int checks = 0;
  int pulsos = 0;
  int mult_ciclos = 0;
  logic [3:0] esperado_q[$];

  detector_jogada dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .habilita     (habilita),
    .jogada       (jogada),
    .jogada_feita (jogada_feita),
    .multipla     (multipla),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Scoreboard side: every pulse must match the oldest queued play.
  always @(negedge clock) begin
    if (multipla === 1'b1) mult_ciclos++;
    if (jogada_feita === 1'b1) begin
      pulsos++;
      checks++;
      if (esperado_q.size() == 0) begin
        errors++;
        $error("FAIL pulso_inesperado: observed=%0h expected=none", jogada);
      end else begin
        logic [3:0] exp;
        exp = esperado_q.pop_front();
        assert (jogada === exp) else begin
          errors++;
          $error("FAIL jogada_pulso: observed=%0h expected=%0h", jogada, exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; botoes = 4'b0000; habilita = 1'b1;
    ciclos(2);
    chk("rst_jogada", jogada, 0);
    chk("rst_feita", jogada_feita, 0);
    chk("rst_multipla", multipla, 0);
    chk("rst_estado", db_estado, 0);
    reset = 1'b0;
    ciclos(3);
    chk("espera_pressao", db_estado, 1);

    // Clean press: pulse between edges 8 and 9.
    botoes = 4'b0001; esperado_q.push_back(4'b0001);
    ciclos(7);
    chk("e7_feita", jogada_feita, 0);
    chk("e7_estado", db_estado, 2);
    ciclos(1);
    chk("e8_feita", jogada_feita, 1);
    chk("e8_jogada", jogada, 1);
    chk("e8_estado", db_estado, 3);
    ciclos(1);
    chk("e9_feita", jogada_feita, 0);
    chk("e9_estado", db_estado, 4);
    ciclos(1);
    botoes = 4'b0000;
    ciclos(10);
    chk("soltou_estado", db_estado, 1);
    chk("pulsos_1", pulsos, 1);
    chk("sem_multipla_1", mult_ciclos, 0);

    // Short glitch is rejected.
    botoes = 4'b0100;
    ciclos(2);
    botoes = 4'b0000;
    ciclos(8);
    chk("glitch_estado", db_estado, 1);
    chk("glitch_jogada", jogada, 1);
    chk("glitch_pulsos", pulsos, 1);

    // Two buttons: multipla once, play unchanged.
    botoes = 4'b0010;
    ciclos(1);
    botoes = 4'b0011;
    ciclos(10);
    botoes = 4'b0000;
    ciclos(12);
    chk("mult_ciclos", mult_ciclos, 1);
    chk("mult_pulsos", pulsos, 1);
    chk("mult_jogada", jogada, 1);
    chk("mult_estado", db_estado, 1);

    // Disabled, then abort mid-filter.
    habilita = 1'b0; botoes = 4'b1000;
    ciclos(10);
    chk("desab_estado", db_estado, 1);
    chk("desab_jogada", jogada, 1);
    habilita = 1'b1;
    ciclos(1);
    chk("hab_filtra", db_estado, 2);
    ciclos(2);
    habilita = 1'b0;
    ciclos(1);
    chk("abort_estado", db_estado, 4);
    botoes = 4'b0000; habilita = 1'b1;
    ciclos(12);
    chk("abort_pulsos", pulsos, 1);
    chk("abort_volta", db_estado, 1);

    // Release bounce yields a single pulse; release filter restarts.
    botoes = 4'b1000; esperado_q.push_back(4'b1000);
    ciclos(10);
    botoes = 4'b0000; ciclos(1);
    botoes = 4'b1000; ciclos(1);
    botoes = 4'b0000; ciclos(7);
    chk("bounce_filtra_soltar", db_estado, 5);
    ciclos(1);
    chk("bounce_liberado", db_estado, 1);
    chk("bounce_pulsos", pulsos, 2);
    chk("bounce_jogada", jogada, 8);
    botoes = 4'b0001; esperado_q.push_back(4'b0001);
    ciclos(10);
    botoes = 4'b0000;
    ciclos(12);
    chk("prox_pulsos", pulsos, 3);
    chk("prox_jogada", jogada, 1);

    // Asynchronous reset during FILTRA drops the pending press.
    botoes = 4'b0100;
    ciclos(4);
    chk("pre_rst_filtra", db_estado, 2);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_jogada", jogada, 0);
    chk("rst_async_estado", db_estado, 0);
    botoes = 4'b0000;
    ciclos(2);
    reset = 1'b0;
    ciclos(12);
    chk("pos_rst_pulsos", pulsos, 3);
    chk("pos_rst_jogada", jogada, 0);
    chk("fila_vazia", esperado_q.size(), 0);
    chk("mult_final", mult_ciclos, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
